// File: rtl/icache_assoc_param_if.sv
// Fetch-side and memory-side signal bundle for icache_assoc_param.
// slave  : cache view (takes fetch requests, issues memory reads)
// master : environment view (fetch stage plus memory controller)
interface icache_assoc_param_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        inval;
  logic        inval_busy;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave  (input  imemREN, imemaddr, inval, iwait, iload,
                  output ihit, imemload, inval_busy, iREN, iaddr);
  modport master (output imemREN, imemaddr, inval, iwait, iload,
                  input  ihit, imemload, inval_busy, iREN, iaddr);
endinterface

// File: rtl/icache_assoc_param.sv
// Parameterised instruction cache: NSETS sets, BLKWORDS words per block,
// 1- or 2-way associativity with one LRU bit per set, burst line fill and
// a one-set-per-cycle full invalidate sweep.
// Optional hit/miss counters are compiled in when ICACHE_STATS_EN is defined.
module icache_assoc_param #(
  parameter int NSETS    = 8,
  parameter int BLKWORDS = 2,
  parameter int NWAYS    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  icache_assoc_param_if.slave   bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam int LBW  = $clog2(BLKWORDS);
  localparam int LSI  = $clog2(NSETS);
  localparam int WIW  = (LBW > 0) ? LBW : 1;
  localparam int TAGW = 30 - LBW - LSI;
  // Forces the word index to zero for single-word blocks.
  localparam logic [WIW-1:0] WI_MASK = WIW'(BLKWORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_INVAL} state_t;

  // Line storage; two ways are always declared, only NWAYS are ever used.
  logic [TAGW-1:0] r_tag   [2][NSETS];
  logic            r_valid [2][NSETS];
  logic [31:0]     r_data  [2][NSETS][BLKWORDS];
  logic            r_lru   [NSETS];

  state_t          r_state;
  logic [WIW-1:0]  r_cnt;
  logic [LSI-1:0]  r_si;
  logic [LSI-1:0]  r_sweep;
  logic [TAGW-1:0] r_ftag;
  logic            r_vic;
  logic            r_pend;

  logic [WIW-1:0]  w_wi;
  logic [LSI-1:0]  w_si;
  logic [TAGW-1:0] w_tag;
  logic            w_hit;
  logic            w_hway;
  logic            w_ihit;
  logic            w_vic;
  logic            w_last;
  logic            w_fill_we;
  logic [31:0]     w_base;

  // Address split: offset bits [1:0] are dropped by the shift.
  assign w_wi  = WIW'(bus.imemaddr >> 2) & WI_MASK;
  assign w_si  = LSI'(bus.imemaddr >> (2 + LBW));
  assign w_tag = TAGW'(bus.imemaddr >> (2 + LBW + LSI));

  // Tag compare across all configured ways of the addressed set.
  always_comb begin
    w_hit  = 1'b0;
    w_hway = 1'b0;
    for (int w = 0; w < NWAYS; w++) begin
      if (r_valid[w][w_si] && (r_tag[w][w_si] == w_tag)) begin
        w_hit  = 1'b1;
        w_hway = 1'(w);
      end
    end
  end

  // Victim: first invalid way (way 0 first), else the LRU way.
  always_comb begin
    w_vic = 1'b0;
    if (NWAYS == 2) begin
      if (!r_valid[0][w_si])      w_vic = 1'b0;
      else if (!r_valid[1][w_si]) w_vic = 1'b1;
      else                        w_vic = r_lru[w_si];
    end
  end

  assign w_ihit    = (r_state == S_IDLE) && bus.imemREN && w_hit;
  assign w_last    = (r_cnt == WIW'(BLKWORDS - 1));
  assign w_fill_we = (r_state == S_FILL) && !bus.iwait && !RST;
  assign w_base    = (32'(r_ftag) << (2 + LBW + LSI)) | (32'(r_si) << (2 + LBW));

  assign bus.ihit       = w_ihit;
  assign bus.imemload   = w_ihit ? r_data[w_hway][w_si][w_wi] : 32'h0;
  assign bus.iREN       = (r_state == S_FILL);
  assign bus.iaddr      = (r_state == S_FILL) ? (w_base + (32'(r_cnt & WI_MASK) << 2)) : 32'h0;
  assign bus.inval_busy = (r_state == S_INVAL) || r_pend;

  // Data array: one word written per accepted memory beat; never reset.
  always_ff @(posedge CLK) begin
    if (w_fill_we) r_data[r_vic][r_si][r_cnt] <= bus.iload;
  end

  // Controller FSM plus tag/valid/LRU state and optional statistics.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_si    <= '0;
      r_sweep <= '0;
      r_ftag  <= '0;
      r_vic   <= 1'b0;
      r_pend  <= 1'b0;
      for (int s = 0; s < NSETS; s++) begin
        r_valid[0][s] <= 1'b0;
        r_valid[1][s] <= 1'b0;
        r_lru[s]      <= 1'b0;
      end
`ifdef ICACHE_STATS_EN
      hit_cnt  <= '0;
      miss_cnt <= '0;
`endif
    end else begin
`ifdef ICACHE_STATS_EN
      if (w_ihit) hit_cnt <= hit_cnt + 32'd1;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_ihit && (NWAYS == 2)) r_lru[w_si] <= ~w_hway;
          // Invalidate wins over a simultaneous miss; the miss replays later.
          if (bus.inval) begin
            r_state <= S_INVAL;
            r_sweep <= '0;
          end else if (bus.imemREN && !w_hit) begin
            r_state <= S_FILL;
            r_ftag  <= w_tag;
            r_si    <= w_si;
            r_vic   <= w_vic;
            r_cnt   <= '0;
            // Drop the victim now so a half-written line can never hit.
            r_valid[w_vic][w_si] <= 1'b0;
`ifdef ICACHE_STATS_EN
            miss_cnt <= miss_cnt + 32'd1;
`endif
          end
        end
        S_FILL: begin
          if (bus.inval) r_pend <= 1'b1;
          if (!bus.iwait) begin
            if (w_last) begin
              r_tag[r_vic][r_si]   <= r_ftag;
              r_valid[r_vic][r_si] <= 1'b1;
              if (NWAYS == 2) r_lru[r_si] <= ~r_vic;
              r_cnt   <= '0;
              r_pend  <= 1'b0;
              r_sweep <= '0;
              r_state <= (r_pend || bus.inval) ? S_INVAL : S_IDLE;
            end else begin
              r_cnt <= r_cnt + WIW'(1);
            end
          end
        end
        S_INVAL: begin
          r_valid[0][r_sweep] <= 1'b0;
          r_valid[1][r_sweep] <= 1'b0;
          r_lru[r_sweep]      <= 1'b0;
          if (r_sweep == LSI'(NSETS - 1)) r_state <= S_IDLE;
          else                            r_sweep <= r_sweep + LSI'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_assoc_param.sv
// Directed bench for icache_assoc_param: a default instance (8 sets,
// 2 words, 1 way) and a 4-set, 4-word, 2-way instance. Expected fill
// addresses and hit data are queued when driven and popped when observed.
module tb_icache_assoc_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        ren [2];
  logic [31:0] addr[2];
  logic        inv [2];
  logic        iw  [2];
  logic        rst [2];
  logic [31:0] salt[2];

  int bwv[2] = '{2, 4};
  int nsv[2] = '{8, 4};

  logic        o_hit [2];
  logic [31:0] o_load[2];
  logic        o_iren[2];
  logic [31:0] o_iadr[2];
  logic        o_busy[2];

  logic [31:0] addr_q[$];
  logic [31:0] data_q[$];

  function automatic logic [31:0] memf(logic [31:0] a, logic [31:0] s);
    return (a * 32'h9E37_79B1) ^ s;
  endfunction

  icache_assoc_param_if b0();
  icache_assoc_param_if b1();

  assign b0.imemREN = ren[0];  assign b1.imemREN = ren[1];
  assign b0.imemaddr = addr[0]; assign b1.imemaddr = addr[1];
  assign b0.inval = inv[0];    assign b1.inval = inv[1];
  assign b0.iwait = iw[0];     assign b1.iwait = iw[1];
  assign b0.iload = memf(b0.iaddr, salt[0]);
  assign b1.iload = memf(b1.iaddr, salt[1]);

  assign o_hit[0] = b0.ihit;        assign o_hit[1] = b1.ihit;
  assign o_load[0] = b0.imemload;   assign o_load[1] = b1.imemload;
  assign o_iren[0] = b0.iREN;       assign o_iren[1] = b1.iREN;
  assign o_iadr[0] = b0.iaddr;      assign o_iadr[1] = b1.iaddr;
  assign o_busy[0] = b0.inval_busy; assign o_busy[1] = b1.inval_busy;

`ifdef ICACHE_STATS_EN
  logic [31:0] hc[2];
  logic [31:0] mc[2];
  icache_assoc_param u0 (.CLK(clk), .RST(rst[0]), .bus(b0), .hit_cnt(hc[0]), .miss_cnt(mc[0]));
  icache_assoc_param #(.NSETS(4), .BLKWORDS(4), .NWAYS(2))
    u1 (.CLK(clk), .RST(rst[1]), .bus(b1), .hit_cnt(hc[1]), .miss_cnt(mc[1]));
`else
  icache_assoc_param u0 (.CLK(clk), .RST(rst[0]), .bus(b0));
  icache_assoc_param #(.NSETS(4), .BLKWORDS(4), .NWAYS(2))
    u1 (.CLK(clk), .RST(rst[1]), .bus(b1));
`endif

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Miss on address a, then the full burst. waits = iwait cycles before each
  // accept; inval_at = fill cycle index carrying an inval pulse (-1: none).
  task automatic fill(int d, logic [31:0] a, int waits, int inval_at);
    logic [31:0] base;
    int cyc;
    ren[d] = 1'b1; addr[d] = a; iw[d] = 1'b0;
    #4;
    chk("miss_ihit", o_hit[d], 0);
    chk("miss_iren", o_iren[d], 0);
    chk("miss_busy", o_busy[d], 0);
    base = a & ~(32'(bwv[d] * 4) - 32'd1);
    for (int k = 0; k < bwv[d]; k++) addr_q.push_back(base + 32'(4 * k));
    step();
    cyc = 0;
    for (int k = 0; k < bwv[d]; k++) begin
      for (int w = 0; w <= waits; w++) begin
        iw[d]  = (w < waits);
        inv[d] = (cyc == inval_at);
        #4;
        chk("fill_iren", o_iren[d], 1);
        chk("fill_iaddr", o_iadr[d], addr_q[0]);
        chk("fill_ihit", o_hit[d], 0);
        if (inval_at >= 0 && cyc > inval_at) chk("fill_busy", o_busy[d], 1);
        if (w == waits) void'(addr_q.pop_front());
        step();
        inv[d] = 1'b0;
        cyc++;
      end
    end
    iw[d] = 1'b0;
  endtask

  task automatic hitchk(int d, logic [31:0] a);
    ren[d] = 1'b1; addr[d] = a;
    data_q.push_back(memf(a, salt[d]));
    #4;
    chk("hit_ihit", o_hit[d], 1);
    chk("hit_iren", o_iren[d], 0);
    chk("hit_data", o_load[d], data_q.pop_front());
    step();
  endtask

  // NSETS sweep cycles; reinv_at pulses inval again mid-sweep (-1: none).
  task automatic sweep(int d, int reinv_at);
    for (int i = 0; i < nsv[d]; i++) begin
      inv[d] = (i == reinv_at);
      #4;
      chk("swp_busy", o_busy[d], 1);
      chk("swp_iren", o_iren[d], 0);
      chk("swp_ihit", o_hit[d], 0);
      step();
      inv[d] = 1'b0;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      ren[d] = 1'b0; addr[d] = '0; inv[d] = 1'b0; iw[d] = 1'b0; rst[d] = 1'b1;
    end
    salt[0] = 32'h1111_0000; salt[1] = 32'h2222_0000;
    step(); step();
    rst[0] = 1'b0; rst[1] = 1'b0;
    #4;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ihit", o_hit[d], 0);
      chk("rst_load", o_load[d], 0);
      chk("rst_iren", o_iren[d], 0);
      chk("rst_iaddr", o_iadr[d], 0);
      chk("rst_busy", o_busy[d], 0);
    end
    step();

    // Cold miss, refetch hit, second word hits with no memory read.
    fill(0, 32'h40, 0, -1);
    hitchk(0, 32'h40);
    hitchk(0, 32'h44);
    // Direct-mapped conflict in set 0 evicts 0x40.
    fill(0, 32'h00, 0, -1);
    hitchk(0, 32'h04);
    fill(0, 32'h40, 0, -1);
    hitchk(0, 32'h40);

    // inval together with a miss: sweep first, re-pulse ignored, miss replays.
    ren[0] = 1'b1; addr[0] = 32'h100; inv[0] = 1'b1;
    #4;
    chk("invm_iren", o_iren[0], 0);
    chk("invm_ihit", o_hit[0], 0);
    step();
    inv[0] = 1'b0;
    sweep(0, 1);
    fill(0, 32'h100, 0, -1);
    hitchk(0, 32'h104);

    // inval in the 2nd fill cycle: fill completes, sweep, refetch misses.
    fill(0, 32'h48, 1, 1);
    sweep(0, -1);
    fill(0, 32'h48, 0, -1);
    hitchk(0, 32'h4C);

    // Reset in the first fill cycle discards the partial line.
    ren[0] = 1'b1; addr[0] = 32'h50;
    #4;
    chk("rmf_miss", o_hit[0], 0);
    step();
    rst[0] = 1'b1;
    #4;
    chk("rmf_iren_fill", o_iren[0], 1);
    step();
    rst[0] = 1'b0; ren[0] = 1'b0;
    #4;
    chk("rmf_iren", o_iren[0], 0);
    chk("rmf_ihit", o_hit[0], 0);
    chk("rmf_busy", o_busy[0], 0);
    step();
    salt[0] = 32'h5A5A_0000;
    fill(0, 32'h50, 0, -1);
    hitchk(0, 32'h50);
    ren[0] = 1'b0;

    // 2-way, 4-word blocks: wait states and LRU replacement in set 0.
    fill(1, 32'h000, 3, -1);
    for (int k = 0; k < 4; k++) hitchk(1, 32'(4 * k));
    fill(1, 32'h100, 0, -1);
    hitchk(1, 32'h104);
    hitchk(1, 32'h008);
    fill(1, 32'h200, 0, -1);
    hitchk(1, 32'h20C);
    hitchk(1, 32'h000);
    fill(1, 32'h100, 0, -1);
    hitchk(1, 32'h100);
    hitchk(1, 32'h004);
    ren[1] = 1'b0;

`ifdef ICACHE_STATS_EN
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    fill(0, 32'h88, 0, -1);
    for (int k = 0; k < 5; k++) hitchk(0, (k % 2 == 0) ? 32'h88 : 32'h8C);
    ren[0] = 1'b0;
    #4;
    chk("st_hit", hc[0], 5);
    chk("st_miss", mc[0], 1);
    step();
    inv[0] = 1'b1;
    step();
    inv[0] = 1'b0;
    sweep(0, -1);
    #4;
    chk("st_hit_inv", hc[0], 5);
    chk("st_miss_inv", mc[0], 1);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
